// File: rtl/weight_skew_fifo.sv
// Weight-staging FIFO for the systolic array: row-wide circular buffer with valid/ready
// handshakes, replay recirculation of popped rows, and a per-lane diagonal skew stage.
module weight_skew_fifo #(
    parameter int LANES  = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int SKEW   = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [LANES*DATA_W-1:0]   wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [LANES*DATA_W-1:0]   rd_data,
    input  logic                      replay,
    output logic [LANES*DATA_W-1:0]   skew_data,
    output logic [LANES-1:0]          skew_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = LANES * DATA_W;

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop, mem_we;
    logic [W-1:0]    mem_wdata;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign rd_valid = !empty;
    assign wr_ready = !full && !replay;
    assign rd_data  = mem_q[rd_ptr_q];

    assign push = wr_valid && wr_ready;
    assign pop  = rd_valid && rd_ready;

    // A replayed pop re-appends the head row at the tail, so it takes the write port.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mem_we    = push || (pop && replay);
        mem_wdata = push ? wr_data : rd_data;

        if (mem_we) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

        if (push && !pop)                count_d = count_q + CW'(1);
        else if (pop && !replay && !push) count_d = count_q - CW'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the row storage is deliberately not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) mem_q[wr_ptr_q] <= mem_wdata;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int LAT = 1 + k * SKEW;

        logic [DATA_W-1:0] dat_q [LAT];
        logic [DATA_W-1:0] dat_d [LAT];
        logic [LAT-1:0]    vld_q, vld_d;

        // Idle slots carry zero data so an invalid lane always reads as zero.
        always_comb begin
            dat_d[0] = pop ? rd_data[k*DATA_W +: DATA_W] : '0;
            vld_d[0] = pop;
            for (int i = 1; i < LAT; i++) begin
                dat_d[i] = dat_q[i-1];
                vld_d[i] = vld_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q <= '0;
                for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end

        assign skew_data[k*DATA_W +: DATA_W] = dat_q[LAT-1];
        assign skew_valid[k]                 = vld_q[LAT-1];
    end

endmodule

// File: tb/tb_weight_skew_fifo.sv
// Self-checking bench for weight_skew_fifo: queue scoreboard for the FIFO, per-cycle pop
// history for both a skewed (SKEW=1) and an aligned (SKEW=0) instance.
module tb_weight_skew_fifo;

    localparam int LANES  = 16;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int W      = LANES * DATA_W;
    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int HMAX   = 1024;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_valid, rd_ready, replay;
    logic [W-1:0]     wr_data;
    logic             wr_ready, rd_valid, full, empty;
    logic [W-1:0]     rd_data, skew_data;
    logic [LANES-1:0] skew_valid;
    logic [CW-1:0]    count;

    logic             wr_ready_0, rd_valid_0, full_0, empty_0;
    logic [W-1:0]     rd_data_0, skew_data_0;
    logic [LANES-1:0] skew_valid_0;
    logic [CW-1:0]    count_0;

    always #5 clk = ~clk;

    weight_skew_fifo #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .SKEW(1)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .replay(replay),
        .skew_data(skew_data), .skew_valid(skew_valid), .count(count), .full(full), .empty(empty)
    );

    weight_skew_fifo #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .SKEW(0)) dut0 (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready_0), .wr_data(wr_data),
        .rd_valid(rd_valid_0), .rd_ready(rd_ready), .rd_data(rd_data_0), .replay(replay),
        .skew_data(skew_data_0), .skew_valid(skew_valid_0), .count(count_0), .full(full_0),
        .empty(empty_0)
    );

    typedef struct {
        logic         wv;
        logic [W-1:0] wd;
        logic         rr;
        logic         rp;
        int           exp_count;
        logic         exp_full;
        logic         exp_wr_ready;
    } vec_t;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [W-1:0] model_q [$];
    logic         hist_v [HMAX];
    logic [W-1:0] hist_d [HMAX];
    vec_t         fill_tab [18];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] mk_row(input int base);
        logic [W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = DATA_W'(base + k);
        return r;
    endfunction

    // One clock: drive inputs, sample at negedge against the scoreboard, advance the model.
    task automatic cycle(input logic wv, input logic [W-1:0] wd, input logic rr,
                         input logic rp, input logic rst);
        logic [W-1:0]     es, es0;
        logic [LANES-1:0] ev, ev0;
        logic             exp_wr_ready, exp_rd_valid, do_push, do_pop;
        logic [W-1:0]     head;
        int               sz, idx;
        wr_valid = wv; wr_data = wd; rd_ready = rr; replay = rp; reset = rst;
        @(negedge clk);
        sz           = model_q.size();
        exp_wr_ready = (sz < DEPTH) && !rp;
        exp_rd_valid = (sz > 0);
        check("count", W'(count), W'(sz));
        check("count_skew0", W'(count_0), W'(sz));
        check("full", W'(full), W'(sz == DEPTH));
        check("empty", W'(empty), W'(sz == 0));
        check("rd_valid", W'(rd_valid), W'(exp_rd_valid));
        check("wr_ready", W'(wr_ready), W'(exp_wr_ready));
        head = exp_rd_valid ? model_q[0] : '0;
        if (exp_rd_valid) check("rd_data", rd_data, head);

        es = '0; ev = '0; es0 = '0; ev0 = '0;
        for (int k = 0; k < LANES; k++) begin
            idx = cyc - 1 - k;
            if (idx >= 0 && hist_v[idx]) begin
                ev[k] = 1'b1;
                es[k*DATA_W +: DATA_W] = hist_d[idx][k*DATA_W +: DATA_W];
            end
            if (cyc >= 1 && hist_v[cyc-1]) begin
                ev0[k] = 1'b1;
                es0[k*DATA_W +: DATA_W] = hist_d[cyc-1][k*DATA_W +: DATA_W];
            end
        end
        check("skew_valid", W'(skew_valid), W'(ev));
        check("skew_data", skew_data, es);
        check("skew0_valid", W'(skew_valid_0), W'(ev0));
        check("skew0_data", skew_data_0, es0);

        do_push = wv && exp_wr_ready;
        do_pop  = rr && exp_rd_valid;
        hist_v[cyc] = do_pop && !rst;
        hist_d[cyc] = head;
        if (rst) begin
            model_q.delete();
            for (int i = 0; i <= cyc; i++) hist_v[i] = 1'b0;
        end else begin
            if (do_pop) begin
                void'(model_q.pop_front());
                if (rp) model_q.push_back(head);
            end
            if (do_push) model_q.push_back(wd);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < HMAX; i++) begin
            hist_v[i] = 1'b0;
            hist_d[i] = '0;
        end
        for (int n = 0; n < 18; n++) begin
            fill_tab[n] = '{wv: (n < 17), wd: (n == 16) ? {LANES{8'hEE}} : mk_row(n * 16),
                            rr: 1'b0, rp: 1'b0, exp_count: (n < 16) ? n + 1 : 16,
                            exp_full: (n >= 15), exp_wr_ready: (n < 15)};
        end

        reset = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; replay = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then fill with rd_ready low; entry 16 is the refused 17th write.
        idle(1);
        for (int n = 0; n < 18; n++) begin
            cycle(fill_tab[n].wv, fill_tab[n].wd, fill_tab[n].rr, fill_tab[n].rp, 1'b0);
            check("fill_count", W'(count), W'(fill_tab[n].exp_count));
            check("fill_full", W'(full), W'(fill_tab[n].exp_full));
            check("fill_wr_ready", W'(wr_ready), W'(fill_tab[n].exp_wr_ready));
        end

        // Drain: rows must come out r_0..r_15 and the refused row never appears.
        for (int n = 0; n < 16; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("drain_empty", W'(empty), W'(1));
        check("drain_rd_valid", W'(rd_valid), W'(0));
        idle(LANES + 1);

        // Single skewed pop: lane k shows k+1 exactly at t+1+k, aligned copy at t+1.
        cycle(1'b1, mk_row(1), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("skew0_all_lanes", W'(skew_valid_0), W'({LANES{1'b1}}));
        for (int k = 0; k < LANES; k++) begin
            check("skew_onehot", W'(skew_valid), W'(LANES'(1) << k));
            check("skew_lane_val", W'(skew_data[k*DATA_W +: DATA_W]), W'(k + 1));
            idle(1);
        end
        check("skew_drained", W'(skew_valid), W'(0));

        // Replay: four rows recirculated twice, external pushes refused throughout.
        for (int n = 0; n < 4; n++) cycle(1'b1, mk_row(64 + n * 16), 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 8; n++) cycle(1'b1, {LANES{8'h5A}}, 1'b1, 1'b1, 1'b0);
        check("replay_count", W'(count), W'(4));
        for (int n = 0; n < 4; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Concurrent push/pop at count 8 across pointer wrap.
        for (int n = 0; n < 8; n++) cycle(1'b1, mk_row(n * 5 + 100), 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++) cycle(1'b1, mk_row(n * 11 + 7), 1'b1, 1'b0, 1'b0);
        check("concurrent_count", W'(count), W'(8));

        // Reset mid-stream with count 10 and a skewed row in flight.
        cycle(1'b1, mk_row(200), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk_row(210), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, mk_row(220), 1'b1, 1'b0, 1'b0);
        idle(2);
        cycle(1'b1, mk_row(230), 1'b1, 1'b0, 1'b1);
        check("rst_count", W'(count), W'(0));
        check("rst_empty", W'(empty), W'(1));
        check("rst_wr_ready", W'(wr_ready), W'(1));
        check("rst_skew_valid", W'(skew_valid), W'(0));
        check("rst_skew_data", skew_data, '0);
        cycle(1'b1, mk_row(33), 1'b0, 1'b0, 1'b0);
        check("post_rst_head", rd_data, mk_row(33));
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle(LANES + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
